// File: rtl/l2_sync_reservation_pkg.sv
// Shared defines for the L2 load-reserved/store-conditional tracker.
// Operation encoding and perf event numbering.
package l2_sync_reservation_pkg;

  typedef enum logic [1:0] {
    SYNC_LOAD  = 2'd0,
    SYNC_STORE = 2'd1,
    STORE      = 2'd2,
    CLEAR      = 2'd3
  } sync_op_t;

  localparam int PERF_SYNC_FAIL  = 0;
  localparam int NUM_PERF_EVENTS = 1;

endpackage

// File: rtl/l2_sync_reservation_if.sv
// Request/response bundle between the L2 pipeline and the reservation unit.
// master drives requests, slave returns SYNC_STORE results.
interface l2_sync_reservation_if
  import l2_sync_reservation_pkg::*;
#(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 26
);

  logic              req_valid;
  sync_op_t          req_op;
  logic [ID_W-1:0]   req_id;
  logic [ADDR_W-1:0] req_line_addr;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_success;

  modport master (
    output req_valid,
    output req_op,
    output req_id,
    output req_line_addr,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_success
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_id,
    input  req_line_addr,
    output rsp_valid,
    output rsp_id,
    output rsp_success
  );

endinterface

// File: rtl/l2_sync_reservation_slot.sv
// One reservation slot: valid bit, line address, age counter
// and the address match against the current request.
module sync_reservation_slot #(
  parameter int ADDR_W         = 26,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              inval,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              valid,
  output logic              valid_next,
  output logic              match
);

  localparam int AGE_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST =
    AGE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [ADDR_W-1:0] addr;
  logic [AGE_W-1:0]  age;
  logic              expire;

  assign match  = valid && (addr == addr_in);
  assign expire = (TIMEOUT_CYCLES > 0) && valid &&
                  (age == AGE_LAST);

  // flush beats a reload, a reload beats expiry
  always_comb begin
    valid_next = valid;
    if (flush)       valid_next = 1'b0;
    else if (load)   valid_next = 1'b1;
    else if (inval)  valid_next = 1'b0;
    else if (expire) valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      addr  <= '0;
      age   <= '0;
    end else begin
      valid <= valid_next;
      if (load) begin
        addr <= addr_in;
        age  <= '0;
      end else if (!valid_next) begin
        age <= '0;
      end else if ((TIMEOUT_CYCLES > 0) &&
                   (age != AGE_LAST)) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_sync_reservation.sv
// L2 reservation tracker for SYNC_LOAD/SYNC_STORE pairs,
// one slot per hardware thread, 1-cycle SYNC_STORE result.
module l2_sync_reservation
  import l2_sync_reservation_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 32,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int TIMEOUT_CYCLES  = 0,
  localparam int ID_W  =
    (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
  localparam int CNT_W = $clog2(NUM_REQUESTERS) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  l2_sync_reservation_if.slave   bus,
  input  logic                   flush_all,
  output logic [CNT_W-1:0]       active_count,
  output logic                   perf_sync_fail
);

  localparam int N = NUM_REQUESTERS;

  logic         is_load;
  logic         is_sstore;
  logic         is_store;
  logic         is_clear;
  logic         id_ok;
  logic         success;
  logic [N-1:0] sel;
  logic [N-1:0] load_v;
  logic [N-1:0] inval_v;
  logic [N-1:0] valid_v;
  logic [N-1:0] valid_nx;
  logic [N-1:0] match_v;
  logic [CNT_W-1:0] count_nx;

  always_comb begin
    is_load   = 1'b0;
    is_sstore = 1'b0;
    is_store  = 1'b0;
    is_clear  = 1'b0;
    if (bus.req_valid) begin
      unique case (1'b1)
        bus.req_op == SYNC_LOAD:  is_load   = 1'b1;
        bus.req_op == SYNC_STORE: is_sstore = 1'b1;
        bus.req_op == STORE:      is_store  = 1'b1;
        bus.req_op == CLEAR:      is_clear  = 1'b1;
        default: ;
      endcase
    end
  end

  assign id_ok = 32'(bus.req_id) < N;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sel[i] = id_ok && (bus.req_id == ID_W'(i));
    end
  end

  // evaluated against the old slot state
  assign success = |(sel & match_v);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      load_v[i]  = is_load && sel[i];
      inval_v[i] = (is_sstore && success && match_v[i]) ||
                   (is_sstore && !success && sel[i]) ||
                   (is_store && match_v[i]) ||
                   (is_clear && sel[i]);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    sync_reservation_slot #(
      .ADDR_W         (LINE_ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_all),
      .load       (load_v[g]),
      .inval      (inval_v[g]),
      .addr_in    (bus.req_line_addr),
      .valid      (valid_v[g]),
      .valid_next (valid_nx[g]),
      .match      (match_v[g])
    );
  end

  always_comb begin
    count_nx = '0;
    for (int i = 0; i < N; i++) begin
      count_nx = count_nx + CNT_W'(valid_nx[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_success <= 1'b0;
      perf_sync_fail  <= 1'b0;
      active_count    <= '0;
    end else begin
      bus.rsp_valid   <= is_sstore;
      bus.rsp_id      <= bus.req_id;
      bus.rsp_success <= is_sstore && success;
      perf_sync_fail  <= is_sstore && !success;
      active_count    <= count_nx;
    end
  end

endmodule
